// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) arbiter onto a single RAM command bus with halt/park and
// saturating completion counters. Define MEM_ARB_FAIR_EN for alternating grant on contention.
module mem_arbiter (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        ram_ready,
  input  logic [31:0] ram_load,
  input  logic        halt,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        parked,
  output logic [15:0] icount,
  output logic [15:0] dcount
);

  typedef enum logic [1:0] {IDLE, IACC, DACC, PARK} state_t;

  state_t      state_reg, state_next;
  logic        dwr_reg, dwr_next;
  logic [15:0] icount_reg, dcount_reg;
  logic        d_req;
  logic        pick_i;
  logic        i_done, d_done;

  assign d_req = dREN | dWEN;

`ifdef MEM_ARB_FAIR_EN
  logic fair_reg;
  // Toggle set means the icache wins the next contended IDLE cycle.
  assign pick_i = iREN & (~d_req | fair_reg);
`else
  assign pick_i = iREN & ~d_req;
`endif

  always_comb begin
    state_next = state_reg;
    dwr_next   = dwr_reg;
    i_done     = 1'b0;
    d_done     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (halt) begin
          state_next = PARK;
        end else if (pick_i) begin
          state_next = IACC;
        end else if (d_req) begin
          state_next = DACC;
          dwr_next   = dWEN;
        end
      end
      IACC: begin
        if (!iREN) begin
          state_next = IDLE;
        end else if (ram_ready) begin
          i_done     = 1'b1;
          state_next = halt ? PARK : IDLE;
        end
      end
      DACC: begin
        if (!d_req) begin
          state_next = IDLE;
        end else if (ram_ready) begin
          d_done     = 1'b1;
          state_next = halt ? PARK : IDLE;
        end
      end
      PARK: begin
        if (!halt) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // RAM strobes come only from registered state so request inputs never reach them combinationally.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0;
    ramstore = 32'h0;
    case (state_reg)
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
      DACC: begin
        ramREN   = ~dwr_reg;
        ramWEN   = dwr_reg;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      default: ;
    endcase
  end

  assign iwait  = iREN & ~i_done;
  assign dwait  = d_req & ~d_done;
  assign iload  = i_done ? ram_load : 32'h0;
  assign dload  = d_done ? ram_load : 32'h0;
  assign parked = (state_reg == PARK);
  assign icount = icount_reg;
  assign dcount = dcount_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= IDLE;
      dwr_reg    <= 1'b0;
      icount_reg <= 16'h0;
      dcount_reg <= 16'h0;
    end else begin
      state_reg <= state_next;
      dwr_reg   <= dwr_next;
      if (i_done && icount_reg != 16'hFFFF) icount_reg <= icount_reg + 16'h1;
      if (d_done && dcount_reg != 16'hFFFF) dcount_reg <= dcount_reg + 16'h1;
    end
  end

`ifdef MEM_ARB_FAIR_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      fair_reg <= 1'b0;
    end else if (i_done || d_done) begin
      fair_reg <= ~fair_reg;
    end
  end
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock; RST  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: iREN  in  1  icache read request; iaddr  in  32  icache word address.
REQ-003 SHALL have ports: dREN  in  1  dcache read request; dWEN  in  1  dcache write request; daddr  in  32  dcache address; dstore  in  32  dcache write data.
REQ-004 SHALL have ports: ram_ready  in  1  RAM access-complete pulse; ram_load  in  32  RAM read data.
REQ-005 SHALL have ports: ramREN  out  1; ramWEN  out  1; ramaddr  out  32; ramstore  out  32  (RAM command bus).
REQ-006 SHALL have ports: iwait  out  1; dwait  out  1  (stall to requester); iload  out  32; dload  out  32.
REQ-007 SHALL have ports: halt  in  1  drain-and-park request; parked  out  1  arbiter idle and parked; icount  out  16; dcount  out  16  (completed-access counters).

Function
REQ-008 SHALL implement FSM states IDLE, IACC, DACC, PARK.
REQ-009 IDLE: dREN|dWEN -> DACC; else iREN -> IACC; else IDLE (fixed data priority, see REQ-024).
REQ-010 SHALL register the grant; the RAM command SHALL appear the cycle after the request is first sampled in IDLE.
REQ-011 In IACC: ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0; in DACC: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore; in IDLE/PARK all RAM outputs SHALL be 0.
REQ-012 dREN and dWEN both high SHALL be treated as a write (ramREN=0, ramWEN=1).
REQ-013 iwait SHALL be 0 only in IACC in the cycle ram_ready=1; dwait likewise for DACC; otherwise each SHALL be 1 while its request is asserted and 0 when not requested.
REQ-014 iload/dload SHALL combinationally pass ram_load during the completing cycle of their own access and be 0 otherwise.
REQ-015 On ram_ready in IACC/DACC: FSM SHALL return to IDLE, or PARK if halt=1.
REQ-016 If the granted requester deasserts its request before ram_ready, the FSM SHALL abort to IDLE next cycle; no counter increment, no wait release.
REQ-017 ram_ready in IDLE or PARK SHALL be ignored.
REQ-018 halt=1 in IDLE SHALL go to PARK next cycle; halt during an access SHALL not abort it.
REQ-019 PARK: parked=1, no grants, iwait/dwait per REQ-013; exit to IDLE only when halt=0.
REQ-020 icount/dcount SHALL increment by 1 on each completed access of that class and saturate at 16'hFFFF.
REQ-021 Only one of ramREN/ramWEN-for-I and D paths SHALL be driven in any cycle; no combinational path from request inputs to RAM outputs.

Reset
REQ-022 RST=1 at a CLK edge SHALL force state IDLE, icount=dcount=0, fairness toggle=0; RAM outputs, parked=0 follow from IDLE.
REQ-023 RST asserted mid-access SHALL drop the access immediately (RAM outputs 0 the following cycle); ram_ready arriving afterward SHALL be ignored.

Configuration
REQ-024 Macro MEM_ARB_FAIR_EN defined: when both I and D request in IDLE, grant alternates using a toggle flipped on every completed access (toggle=0 -> D first); undefined: fixed data priority of REQ-009.
REQ-025 Single-requester behaviour SHALL be identical with and without MEM_ARB_FAIR_EN.

Verification
REQ-026 iREN=1, iaddr=0x40; ram_ready after 3 cycles, ram_load=0xDEADBEEF -> ramREN=1, ramaddr=0x40, iwait low 1 cycle, iload=0xDEADBEEF, icount=1.
REQ-027 iREN=dWEN=1 same cycle, daddr=0x80, dstore=0x1234 -> DACC first with ramWEN=1, ramstore=0x1234; IACC follows; with MEM_ARB_FAIR_EN, second contention grants I first.
REQ-028 dREN dropped mid-DACC -> IDLE next cycle, dcount unchanged, late ram_ready ignored.
REQ-029 halt=1 during IACC -> access completes, then PARK with parked=1; new iREN held with iwait=1 until halt=0.
REQ-030 Force dcount=0xFFFF (0xFFFF completions or preload) plus one more write -> dcount stays 0xFFFF.
REQ-031 RST=1 mid-DACC -> next cycle all RAM outputs 0, counters 0, state IDLE.
